// File: rtl/rotation_aligner_4bit_if.sv
`default_nettype none
// ============================================================================
// Module      : rotation_aligner_4bit_if
// Description : Bundle for the rotated 4-bit link and the aligned output side
//               of rotation_aligner_4bit.
//               din/din_valid  : rotated input words from the link
//               dout/dout_valid: de-rotated data words, one-cycle pulse each
//               locked/rot_amt : lock status and detected left-rotation
//               master modport : link driver / consumer side
//               slave modport  : aligner side
// Revision    : 1.0 - initial release
// ============================================================================
interface rotation_aligner_4bit_if;
  logic [3:0] din;
  logic       din_valid;
  logic [3:0] dout;
  logic       dout_valid;
  logic       locked;
  logic [1:0] rot_amt;

  modport master (
    output din, din_valid,
    input  dout, dout_valid, locked, rot_amt
  );

  modport slave (
    input  din, din_valid,
    output dout, dout_valid, locked, rot_amt
  );
endinterface
`default_nettype wire

// File: rtl/rotation_aligner_4bit.sv
`default_nettype none
// ============================================================================
// Module      : rotation_aligner_4bit
// Description : Finds the constant rotation applied to a framed 4-bit stream
//               from the marker word at frame position 0, and once locked
//               rotates every data word back to its original orientation.
//               clk  : rising-edge clock
//               rst  : asynchronous active-high reset
//               bus  : slave side of rotation_aligner_4bit_if
//                      (din, din_valid in; dout, dout_valid, locked,
//                       rot_amt out)
// Revision    : 1.0 - initial release
// ============================================================================
module rotation_aligner_4bit #(
  parameter logic [3:0] MARKER     = 4'b0001,
  parameter int         FRAME_LEN  = 4,
  parameter int         LOCK_COUNT = 3,
  parameter int         LOSS_COUNT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  rotation_aligner_4bit_if.slave  bus
);

  localparam int POS_W   = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam int CNT_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [3:0] rotl4(input logic [3:0] x, input logic [1:0] k);
    case (k)
      2'd0:    rotl4 = x;
      2'd1:    rotl4 = {x[2:0], x[3]};
      2'd2:    rotl4 = {x[1:0], x[3:2]};
      default: rotl4 = {x[0], x[3:1]};
    endcase
  endfunction

  function automatic logic [3:0] rotr4(input logic [3:0] x, input logic [1:0] k);
    case (k)
      2'd0:    rotr4 = x;
      2'd1:    rotr4 = {x[0], x[3:1]};
      2'd2:    rotr4 = {x[1:0], x[3:2]};
      default: rotr4 = {x[2:0], x[3]};
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       cand_q, cand_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [1:0]       rot_amt_q, rot_amt_d;
  logic [3:0]       dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  // One comparator per possible rotation of the marker; the marker's
  // rotations are distinct, so at most one bit can be set.
  logic [3:0] marker_hit;
  for (genvar k = 0; k < 4; k++) begin : g_marker_cmp
    assign marker_hit[k] = (bus.din == rotl4(MARKER, 2'(k)));
  end

  logic       hit_any;
  logic [1:0] hit_k;
  always_comb begin
    hit_any = |marker_hit;
    hit_k   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (marker_hit[k]) hit_k = 2'(k);
    end
  end

  logic             cand_match;
  logic             lock_match;
  logic [POS_W-1:0] pos_next;
  assign cand_match = (bus.din == rotl4(MARKER, cand_q));
  assign lock_match = (bus.din == rotl4(MARKER, rot_amt_q));
  assign pos_next   = (pos_q == POS_W'(FRAME_LEN - 1)) ? '0 : pos_q + POS_W'(1);

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    pos_d        = pos_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    rot_amt_d    = rot_amt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    if (bus.din_valid) begin
      case (state_q)
        ST_SEARCH: begin
          if (hit_any) begin
            cand_d      = hit_k;
            pos_d       = POS_W'(1);
            match_cnt_d = CNT_W'(1);
            if (LOCK_COUNT == 1) begin
              state_d    = ST_LOCKED;
              rot_amt_d  = hit_k;
              miss_cnt_d = '0;
            end else begin
              state_d = ST_VERIFY;
            end
          end
        end

        ST_VERIFY: begin
          pos_d = pos_next;
          if (pos_q == '0) begin
            if (cand_match) begin
              match_cnt_d = match_cnt_q + CNT_W'(1);
              if (match_cnt_d == CNT_W'(LOCK_COUNT)) begin
                state_d    = ST_LOCKED;
                rot_amt_d  = cand_q;
                miss_cnt_d = '0;
              end
            end else begin
              // The failing word is dropped, not re-tried as a new candidate.
              state_d = ST_SEARCH;
            end
          end
        end

        ST_LOCKED: begin
          pos_d = pos_next;
          if (pos_q != '0) begin
            dout_d       = rotr4(bus.din, rot_amt_q);
            dout_valid_d = 1'b1;
          end else if (lock_match) begin
            miss_cnt_d = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
            if (miss_cnt_d == CNT_W'(LOSS_COUNT)) begin
              state_d    = ST_SEARCH;
              miss_cnt_d = '0;
            end
          end
        end

        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SEARCH;
      cand_q       <= 2'd0;
      pos_q        <= '0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      rot_amt_q    <= 2'd0;
      dout_q       <= 4'd0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      pos_q        <= pos_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      rot_amt_q    <= rot_amt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.locked     = (state_q == ST_LOCKED);
  assign bus.rot_amt    = rot_amt_q;

endmodule
`default_nettype wire

// File: tb/tb_rotation_aligner_4bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotation_aligner_4bit
// Description : Self-checking bench for rotation_aligner_4bit with default
//               parameters; directed frames plus randomized streams compared
//               against a behavioural model of the alignment rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotation_aligner_4bit;

  localparam int MARKER = 1;
  localparam int FLEN   = 4;
  localparam int NLOCK  = 3;
  localparam int NLOSS  = 2;

  logic clk;
  logic rst;
  rotation_aligner_4bit_if bus_if ();

  rotation_aligner_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: mode 0 = searching, 1 = verifying, 2 = locked.
  int         m_mode, m_cand, m_pos, m_good, m_bad, m_rot;
  logic [3:0] m_dout;
  logic       m_dv;

  function automatic int rl(input int x, input int k);
    return ((x << k) | (x >> (4 - k))) & 15;
  endfunction

  function automatic int rr(input int x, input int k);
    return ((x >> k) | (x << (4 - k))) & 15;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cand = 0; m_pos = 0; m_good = 0; m_bad = 0; m_rot = 0;
    m_dout = 4'd0; m_dv = 1'b0;
  endtask

  task automatic model_word(input int w);
    m_dv = 1'b0;
    if (m_mode == 0) begin
      for (int k = 0; k < 4; k++) begin
        if (w == rl(MARKER, k)) begin
          m_cand = k; m_pos = 1; m_good = 1; m_mode = 1;
        end
      end
    end else if (m_mode == 1) begin
      if (m_pos == 0) begin
        if (w == rl(MARKER, m_cand)) begin
          m_good++;
          if (m_good == NLOCK) begin m_mode = 2; m_rot = m_cand; m_bad = 0; end
        end else begin
          m_mode = 0;
        end
      end
      m_pos = (m_pos + 1) % FLEN;
    end else begin
      if (m_pos != 0) begin
        m_dout = 4'(rr(w, m_rot));
        m_dv   = 1'b1;
      end else if (w == rl(MARKER, m_rot)) begin
        m_bad = 0;
      end else begin
        m_bad++;
        if (m_bad == NLOSS) begin m_mode = 0; m_bad = 0; end
      end
      m_pos = (m_pos + 1) % FLEN;
    end
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (bus_if.dout_valid === m_dv) else begin
      errors++;
      $error("FAIL %s dout_valid got %b want %b", tag, bus_if.dout_valid, m_dv);
    end
    checks++;
    assert (bus_if.locked === (m_mode == 2)) else begin
      errors++;
      $error("FAIL %s locked got %b want %0d", tag, bus_if.locked, (m_mode == 2));
    end
    checks++;
    assert (bus_if.rot_amt === 2'(m_rot)) else begin
      errors++;
      $error("FAIL %s rot_amt got %0d want %0d", tag, bus_if.rot_amt, m_rot);
    end
    checks++;
    assert (bus_if.dout === m_dout) else begin
      errors++;
      $error("FAIL %s dout got %b want %b", tag, bus_if.dout, m_dout);
    end
  endtask

  task automatic cyc(input logic v, input int w, input string tag);
    bus_if.din       = 4'(w);
    bus_if.din_valid = v;
    @(posedge clk);
    #1;
    if (v) model_word(w);
    else   m_dv = 1'b0;
    check_outputs(tag);
  endtask

  task automatic frame(input int mk, input int d1, input int d2, input int d3,
                       input bit gaps, input string tag);
    int words[4];
    words = '{mk, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        int n;
        n = $urandom_range(1, 3);
        for (int g = 0; g < n; g++) cyc(1'b0, $urandom_range(0, 15), tag);
      end
      cyc(1'b1, words[i], tag);
    end
  endtask

  task automatic expect_bit(input logic got, input logic want, input string tag);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %b want %b", tag, got, want);
    end
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    bus_if.din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.din = 4'd0;
    bus_if.din_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // Rotation 1: marker 0010, data 0110 -> 0011.
    for (int f = 0; f < 5; f++) frame(4'b0010, 4'b0110, 4'b0110, 4'b0110, 1'b0, "rot1");
    expect_bit(bus_if.locked, 1'b1, "rot1_locked");
    expect_bit(bus_if.rot_amt == 2'd1, 1'b1, "rot1_amt");
    expect_bit(bus_if.dout == 4'b0011, 1'b1, "rot1_dout");

    // Rotation 3.
    async_reset("rst_a");
    for (int f = 0; f < 5; f++) frame(4'b1000, 4'b0100, 4'b1100, 4'b0010, 1'b0, "rot3");
    expect_bit(bus_if.rot_amt == 2'd3, 1'b1, "rot3_amt");

    // False candidate: 0100 enters verify with cand 2, 1111 at pos 0 rejects it.
    async_reset("rst_b");
    cyc(1'b1, 4'b0100, "false");
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0011, "false");
    cyc(1'b1, 4'b1111, "false");
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0011, "false");
    expect_bit(bus_if.locked, 1'b0, "false_unlocked");

    // Loss of lock.
    async_reset("rst_c");
    for (int f = 0; f < 3; f++) frame(4'b0010, 4'b0110, 4'b1010, 4'b1110, 1'b0, "loss_lock");
    frame(4'b0000, 4'b0110, 4'b1010, 4'b1110, 1'b0, "loss_one");
    frame(4'b0010, 4'b0110, 4'b1010, 4'b1110, 1'b0, "loss_good");
    expect_bit(bus_if.locked, 1'b1, "loss_still_locked");
    frame(4'b0000, 4'b0110, 4'b1010, 4'b1110, 1'b0, "loss_two");
    frame(4'b0000, 4'b0110, 4'b1010, 4'b1110, 1'b0, "loss_two");
    expect_bit(bus_if.locked, 1'b0, "loss_dropped");
    for (int f = 0; f < 4; f++) frame(4'b0010, 4'b0110, 4'b1010, 4'b1110, 1'b0, "relock");

    // Stalls inside the rotation-1 stream.
    async_reset("rst_d");
    for (int f = 0; f < 6; f++) frame(4'b0010, 4'b0110, 4'b0110, 4'b0110, 1'b1, "stall");

    // Randomized streams: random rotation, data, corrupt markers and gaps.
    for (int seg = 0; seg < 8; seg++) begin
      int k;
      k = $urandom_range(0, 3);
      for (int f = 0; f < 8; f++) begin
        int mk;
        mk = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : rl(MARKER, k);
        frame(mk, rl($urandom_range(0, 15), k), rl($urandom_range(0, 15), k),
              rl($urandom_range(0, 15), k), 1'b1, "random");
      end
    end

    // Async reset while locked, then reacquire.
    async_reset("rst_e");
    for (int f = 0; f < 4; f++) frame(4'b0100, 4'b1000, 4'b0001, 4'b1100, 1'b0, "pre_rst");
    expect_bit(bus_if.locked, 1'b1, "pre_rst_locked");
    bus_if.din = 4'b1000;
    bus_if.din_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    bus_if.din_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int f = 0; f < 4; f++) frame(4'b0100, 4'b1000, 4'b0001, 4'b1100, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
